shift_chain_ctrl: RTL and testbench
===================================

Name: shift_chain_ctrl

Overview:
- Controller plus embedded storage chain for sequenced load/drain of 16-bit superfloat words: fills a DEPTH-stage shift chain from a valid/ready stream, holds it, then drains it in order to a valid/ready consumer with backpressure.
- Sits between the weight/activation source and the PE array.
- Replaces free-running shift_en pulsing with a counted, handshaked sequence.

Parameters:
- SIZE, 16, word width in bits.
- DEPTH, 8, chain stages; must be >= 2.
- CW (localparam), $clog2(DEPTH+1), counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start_fill  in  1  pulse; honoured only in IDLE.
- start_drain  in  1  pulse; honoured only in FULL.
- abort  in  1  synchronous clear; highest priority.
- in_valid  in  1  producer word valid.
- in_data  in  SIZE  producer word.
- in_ready  out  1  controller accepts in_data this cycle.
- out_valid  out  1  out_data holds a drained word.
- out_data  out  SIZE  drained word (registered).
- out_ready  in  1  consumer accepts.
- busy  out  1  state != IDLE.
- full  out  1  state == FULL.
- done  out  1  one-cycle pulse at drain completion.
- fill_count  out  CW  words accepted in the current fill.

Behaviour:
- Reset (reset low, async): state IDLE; all stages, out_data, fill_count, shift counter = 0; in_ready, out_valid, done = 0.
- States: IDLE, FILL, FULL, DRAIN (enum).
- IDLE -> FILL on start_fill; fill_count cleared on entry.
- FILL:
  - in_ready = 1.
  - On in_valid & in_ready: shift chain (stage0 <= in_data, stage[i] <= stage[i-1]), fill_count++.
  - On the DEPTH-th accept -> FULL (in_ready low the following cycle).
- FULL: in_ready = 0, full = 1, chain frozen. start_drain -> DRAIN with shift counter = DEPTH.
- DRAIN:
  - Shift when counter > 0 and (!out_valid | out_ready): out_data <= stage[DEPTH-1], stage0 <= 0, out_valid <= 1, counter--.
  - When counter == 0 and out_valid & out_ready: out_valid <= 0, done pulse, -> IDLE.
  - Output order equals input order (first word in, first word out).
  - Throughput 1 word/cycle with out_ready held high; first out_valid 1 cycle after entering DRAIN.
  - out_data stable while out_valid & !out_ready.
- abort (any state): next cycle IDLE; chain, out_data, fill_count = 0; out_valid = 0; no done pulse. Abort beats a simultaneous start_*, accept or shift.
- start_fill outside IDLE and start_drain outside FULL are ignored.
- in_valid outside FILL: no effect.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: SHIFT_CHAIN_CTRL_RECIRC_EN.
- Defined:
  - Adds input port recirc (1 bit), sampled on start_drain.
  - If recirc = 1: each drain shift writes stage0 <= stage[DEPTH-1] instead of 0.
  - Completion -> FULL (not IDLE), with the chain restored to its pre-drain contents. done still pulses.
- Undefined: no recirc port; zero-fill, return to IDLE.

Decomposition:
- Package shift_chain_ctrl_pkg:
  - state_t enum {IDLE, FILL, FULL, DRAIN}.
  - Default SIZE/DEPTH constants.
- Sub-module shift_chain: DEPTH x SIZE register chain with shift_en, clear, din, tail output. The controller owns the FSM, counters and out_data register.

Test Plan:
- Reset then fill: start_fill; feed 0x0001..0x0008 back-to-back -> in_ready drops after the 8th accept; full = 1; fill_count = 8.
- Drain with out_ready = 1: start_drain -> out_data 0x0001..0x0008 on 8 consecutive cycles; done pulses 1 cycle after the last transfer; busy = 0.
- Backpressure: out_ready toggled 1,0,0,1 -> out_data holds 0x0003 through stalled cycles; no word lost or duplicated; total 8 words.
- Abort after 5 fill accepts, coincident with in_valid -> state IDLE; fill_count = 0; a subsequent drain-less fill restarts at count 0.
- Async reset low mid-DRAIN (after 3 words) -> out_valid = 0 and out_data = 0 immediately; IDLE after release.
- RECIRC_EN: fill 0xA0..0xA7; drain with recirc = 1 -> outputs 0xA0..0xA7; ends in FULL; second drain (recirc = 0) outputs 0xA0..0xA7 again, then IDLE.

Source files
------------

// File: rtl/shift_chain_ctrl_pkg.sv
// Shared types and default sizing for the shift_chain_ctrl load/drain controller.
package shift_chain_ctrl_pkg;

    localparam int unsigned DEFAULT_SIZE  = 16;
    localparam int unsigned DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL,
        DRAIN
    } state_t;

endpackage

// File: rtl/shift_chain.sv
// DEPTH x SIZE register chain: stage0 takes din on shift, the tail is stage[DEPTH-1].
module shift_chain #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_shift_en,
    input  logic            i_clear,
    input  logic [SIZE-1:0] i_din,
    output logic [SIZE-1:0] o_tail
);

    logic [SIZE-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (i_clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (i_shift_en) begin
            r_stage[0] <= i_din;
            for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_tail = r_stage[DEPTH-1];

endmodule

// File: rtl/shift_chain_ctrl.sv
// Counted, handshaked fill/hold/drain controller around a shift_chain.
// Define SHIFT_CHAIN_CTRL_RECIRC_EN to add the recirc port (non-destructive drain back to FULL).
module shift_chain_ctrl
    import shift_chain_ctrl_pkg::*;
#(
    parameter  int unsigned SIZE  = DEFAULT_SIZE,
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_fill,
    input  logic            start_drain,
    input  logic            abort,
`ifdef SHIFT_CHAIN_CTRL_RECIRC_EN
    input  logic            recirc,
`endif
    input  logic            in_valid,
    input  logic [SIZE-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    input  logic            out_ready,
    output logic            busy,
    output logic            full,
    output logic            done,
    output logic [CW-1:0]   fill_count
);

    state_t          r_state, w_next_state;
    logic [CW-1:0]   r_fill_count, r_shift_cnt;
    logic [SIZE-1:0] r_out_data, w_tail, w_chain_din;
    logic            r_out_valid, r_done;
    logic            w_accept, w_drain_shift, w_drain_last, w_recirc_sel;
    logic            w_start_fill, w_start_drain;

    assign w_start_fill  = (r_state == IDLE)  && start_fill  && !abort;
    assign w_start_drain = (r_state == FULL)  && start_drain && !abort;
    assign w_accept      = (r_state == FILL)  && in_valid    && !abort;
    assign w_drain_shift = (r_state == DRAIN) && (r_shift_cnt != '0)
                           && (!r_out_valid || out_ready) && !abort;
    assign w_drain_last  = (r_state == DRAIN) && (r_shift_cnt == '0)
                           && r_out_valid && out_ready && !abort;

`ifdef SHIFT_CHAIN_CTRL_RECIRC_EN
    logic r_recirc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             r_recirc <= 1'b0;
        else if (abort)         r_recirc <= 1'b0;
        else if (w_start_drain) r_recirc <= recirc;
    end

    assign w_recirc_sel = r_recirc;
`else
    assign w_recirc_sel = 1'b0;
`endif

    // Recirculating the tail for DEPTH shifts rotates the chain back to its pre-drain contents.
    assign w_chain_din = w_accept ? in_data : (w_recirc_sel ? w_tail : '0);

    shift_chain #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) u_chain (
        .clk        (clk),
        .rst_n      (reset),
        .i_shift_en (w_accept || w_drain_shift),
        .i_clear    (abort),
        .i_din      (w_chain_din),
        .o_tail     (w_tail)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start_fill) w_next_state = FILL;
                FILL:    if (w_accept && (r_fill_count == CW'(DEPTH - 1))) w_next_state = FULL;
                FULL:    if (start_drain) w_next_state = DRAIN;
                DRAIN:   if (w_drain_last) w_next_state = w_recirc_sel ? FULL : IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (r_state == FILL) && !abort;
        busy     = (r_state != IDLE);
        full     = (r_state == FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill_count <= '0;
            r_shift_cnt  <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_fill_count <= '0;
                r_shift_cnt  <= '0;
                r_out_data   <= '0;
                r_out_valid  <= 1'b0;
            end else begin
                if (w_start_fill)  r_fill_count <= '0;
                else if (w_accept) r_fill_count <= r_fill_count + 1'b1;

                if (w_start_drain)      r_shift_cnt <= CW'(DEPTH);
                else if (w_drain_shift) r_shift_cnt <= r_shift_cnt - 1'b1;

                if (w_drain_shift) begin
                    r_out_data  <= w_tail;
                    r_out_valid <= 1'b1;
                end else if (w_drain_last) begin
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b1;
                end
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign done       = r_done;
    assign fill_count = r_fill_count;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Scoreboard bench for shift_chain_ctrl: filled words are queued as expected drain output, a monitor pops on each transfer.
module tb_shift_chain_ctrl;

    localparam int unsigned SIZE  = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start_fill = 1'b0, start_drain = 1'b0, abort = 1'b0;
    logic            recirc = 1'b0;
    logic            in_valid = 1'b0, out_ready = 1'b0;
    logic [SIZE-1:0] in_data = '0;
    logic            in_ready, out_valid, busy, full, done;
    logic [SIZE-1:0] out_data;
    logic [CW-1:0]   fill_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;

    logic [SIZE-1:0] q_chain[$];
    logic [SIZE-1:0] q_exp[$];

    always #5 clk = ~clk;

    shift_chain_ctrl #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_fill  (start_fill),
        .start_drain (start_drain),
        .abort       (abort),
`ifdef SHIFT_CHAIN_CTRL_RECIRC_EN
        .recirc      (recirc),
`endif
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .full        (full),
        .done        (done),
        .fill_count  (fill_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int mode, input int unsigned c);
        case (mode)
            0:       return 1'b1;
            1:       return ((c % 4) == 0) || ((c % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Monitor: transfers complete at the next rising edge; inputs are stable from here to it.
    logic            prev_stall = 1'b0;
    logic [SIZE-1:0] prev_data  = '0;
    logic [SIZE-1:0] exp_word;

    always @(negedge clk) begin
        if (reset && !abort) begin
            if (prev_stall && out_valid) check("out_hold", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no transfer", out_data);
                end else begin
                    exp_word = q_exp.pop_front();
                    check("out_data", out_data, exp_word);
                    n_xfer++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_fill(input bit gaps, input bit incr, input logic [SIZE-1:0] base);
        start_fill = 1'b1;
        step();
        start_fill = 1'b0;
        check("fill_count_start", fill_count, 0);
        check("busy_fill", busy, 1);
        q_chain.delete();
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (gaps) begin
                int unsigned g;
                g = $urandom_range(0, 2);
                in_valid = 1'b0;
                in_data  = SIZE'($urandom);
                repeat (g) step();
            end
            in_valid = 1'b1;
            in_data  = incr ? base + SIZE'(k) : SIZE'($urandom);
            check("in_ready_fill", in_ready, 1);
            q_chain.push_back(in_data);
            step();
        end
        in_valid = 1'b0;
        check("in_ready_full", in_ready, 0);
        check("full", full, 1);
        check("fill_count_full", fill_count, DEPTH);
    endtask

    task automatic do_drain(input int mode, input bit rc);
        int unsigned cyc;
        bit          seen;
        check("full_before_drain", full, 1);
        foreach (q_chain[i]) q_exp.push_back(q_chain[i]);
        n_xfer      = 0;
        recirc      = rc;
        start_drain = 1'b1;
        out_ready   = rdy(mode, 0);
        step();
        start_drain = 1'b0;
        recirc      = 1'b0;
        check("out_valid_drain_entry", out_valid, 0);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 200) begin
            out_ready = rdy(mode, cyc + 1);
            step();
            cyc++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got no done in %0d cycles, expected done", cyc);
        end
        if (mode == 0) check("drain_latency", cyc, DEPTH + 1);
        check("busy_after_drain", busy, rc ? 1 : 0);
        check("full_after_drain", full, rc ? 1 : 0);
        check("out_valid_after_drain", out_valid, 0);
        check("words_drained", n_xfer, DEPTH);
        check("scoreboard_empty", q_exp.size(), 0);
        out_ready = 1'b0;
        step();
        check("done_one_cycle", done, 0);
        if (!rc) q_chain.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
        check("rst_fill_count", fill_count, 0);
        reset = 1'b1;
        step();

        start_drain = 1'b1;
        step();
        start_drain = 1'b0;
        check("drain_ignored_idle", busy, 0);

        do_fill(0, 1, 16'h0001);
        start_fill = 1'b1;
        in_valid   = 1'b1;
        in_data    = SIZE'($urandom);
        step();
        start_fill = 1'b0;
        in_valid   = 1'b0;
        check("fill_ignored_full", full, 1);
        check("in_valid_ignored_full", fill_count, DEPTH);
        do_drain(0, 0);

        do_fill(0, 1, 16'h0001);
        do_drain(1, 0);

        repeat (4) begin
            do_fill(1, 0, '0);
            do_drain(2, 0);
        end

        // Abort coincident with the 6th accept
        start_fill = 1'b1;
        step();
        start_fill = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = SIZE'($urandom);
            step();
        end
        check("fill_count_5", fill_count, 5);
        in_valid = 1'b1;
        abort    = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_fill_busy", busy, 0);
        check("abort_fill_count", fill_count, 0);
        check("abort_fill_in_ready", in_ready, 0);
        q_chain.delete();
        do_fill(1, 0, '0);
        do_drain(2, 0);

        // Abort mid-drain
        do_fill(0, 0, '0);
        foreach (q_chain[i]) q_exp.push_back(q_chain[i]);
        start_drain = 1'b1;
        out_ready   = 1'b1;
        step();
        start_drain = 1'b0;
        repeat (3) step();
        out_ready = 1'b0;
        abort     = 1'b1;
        q_exp.delete();
        step();
        abort = 1'b0;
        check("abort_drain_out_valid", out_valid, 0);
        check("abort_drain_out_data", out_data, 0);
        check("abort_drain_done", done, 0);
        check("abort_drain_busy", busy, 0);
        step();
        check("abort_drain_no_done", done, 0);
        q_chain.delete();

        // Asynchronous reset mid-drain
        do_fill(0, 0, '0);
        foreach (q_chain[i]) q_exp.push_back(q_chain[i]);
        start_drain = 1'b1;
        out_ready   = 1'b1;
        step();
        start_drain = 1'b0;
        repeat (3) step();
        #2;
        reset = 1'b0;
        q_exp.delete();
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_busy", busy, 0);
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("post_rst_busy", busy, 0);
        check("post_rst_fill_count", fill_count, 0);
        q_chain.delete();

`ifdef SHIFT_CHAIN_CTRL_RECIRC_EN
        do_fill(0, 1, 16'h00A0);
        do_drain(0, 1);
        do_drain(0, 0);
`endif

        do_fill(1, 0, '0);
        do_drain(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
